cw305_reg_mailbox_fifo: RTL and testbench

//  Parametrised host<->PULPino mailbox. Replaces single-word data/flag registers with two FIFOs.

---
 rtl/cw305_reg_mailbox_fifo_if.sv | 34 +++
 rtl/cw305_reg_mailbox_fifo.sv | 175 +++++++++++++++++
 tb/tb_cw305_reg_mailbox_fifo.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cw305_reg_mailbox_fifo_if.sv
// Bus bundle between the USB register front-end / PULPino core and the mailbox.
// The master modport is the host+core side; the slave modport is the mailbox itself.
interface cw305_reg_mailbox_fifo_if #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pDATA_WIDTH   = 32
);
    logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
    logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
    logic [7:0]                           write_data;
    logic [7:0]                           read_data;
    logic                                 reg_read;
    logic                                 reg_write;
    logic                                 reg_addrvalid;
    logic [pDATA_WIDTH-1:0]               O_h2c_data;
    logic                                 O_h2c_valid;
    logic                                 I_h2c_ready;
    logic [pDATA_WIDTH-1:0]               I_c2h_data;
    logic                                 I_c2h_valid;
    logic                                 O_c2h_ready;
    logic                                 O_irq;

    modport master (
        output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        output I_h2c_ready, I_c2h_data, I_c2h_valid,
        input  read_data, O_h2c_data, O_h2c_valid, O_c2h_ready, O_irq
    );

    modport slave (
        input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
        input  I_h2c_ready, I_c2h_data, I_c2h_valid,
        output read_data, O_h2c_data, O_h2c_valid, O_c2h_ready, O_irq
    );
endinterface

// File: rtl/cw305_reg_mailbox_fifo.sv
// Host<->PULPino mailbox: byte-serial register access on the host side, two word FIFOs
// (host->core and core->host) with valid/ready streams, level counters and sticky error flags.
module cw305_reg_mailbox_fifo #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pDATA_WIDTH   = 32,
    parameter int pDEPTH        = 8,
    parameter int pREG_BASE     = 8
) (
    input logic                    usb_clk,
    input logic                    reset_i,
    cw305_reg_mailbox_fifo_if.slave bus
);
    localparam int NB = pDATA_WIDTH / 8;
    localparam int LW = $clog2(pDEPTH) + 1;
    localparam int PW = LW - 1;
    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;

    localparam logic [AW-1:0] A_H2C_DATA  = AW'(pREG_BASE + 0);
    localparam logic [AW-1:0] A_C2H_DATA  = AW'(pREG_BASE + 1);
    localparam logic [AW-1:0] A_STATUS    = AW'(pREG_BASE + 2);
    localparam logic [AW-1:0] A_H2C_LEVEL = AW'(pREG_BASE + 3);
    localparam logic [AW-1:0] A_C2H_LEVEL = AW'(pREG_BASE + 4);
    localparam logic [AW-1:0] A_CTRL      = AW'(pREG_BASE + 5);

    logic [pDATA_WIDTH-1:0] h2c_mem [pDEPTH];
    logic [pDATA_WIDTH-1:0] c2h_mem [pDEPTH];

    logic [PW-1:0]          h2c_wp, h2c_rp, c2h_wp, c2h_rp;
    logic [PW-1:0]          h2c_wp_d, h2c_rp_d, c2h_wp_d, c2h_rp_d;
    logic [LW-1:0]          h2c_level, c2h_level, h2c_level_d, c2h_level_d;
    logic [pDATA_WIDTH-1:0] asm_q, asm_d, push_word, c2h_head;
    logic                   h2c_ovf, c2h_udf, h2c_ovf_d, c2h_udf_d;
    logic                   rd_q, irq_q, irq_d;
    logic [7:0]             read_data_q, read_data_d, rd_byte, status;

    logic wr, rd_edge, lane_ok, lane_last, lane_zero;
    logic sel_h2c, sel_c2h, sel_status, sel_h2c_lvl, sel_c2h_lvl, sel_ctrl;
    logic h2c_empty, h2c_full, c2h_empty, c2h_full;
    logic h2c_wr, h2c_wr_last, h2c_push, h2c_pop;
    logic c2h_rd, c2h_push, c2h_pop;
    logic ctrl_wr, flush_h2c, flush_c2h, clr_sticky;

    assign wr        = bus.reg_addrvalid & bus.reg_write;
    // A held reg_read only acts on its first cycle.
    assign rd_edge   = bus.reg_addrvalid & bus.reg_read & ~rd_q;
    assign lane_ok   = bus.reg_bytecnt < pBYTECNT_SIZE'(NB);
    assign lane_last = bus.reg_bytecnt == pBYTECNT_SIZE'(NB - 1);
    assign lane_zero = bus.reg_bytecnt == '0;

    assign sel_h2c     = bus.reg_address == A_H2C_DATA;
    assign sel_c2h     = bus.reg_address == A_C2H_DATA;
    assign sel_status  = bus.reg_address == A_STATUS;
    assign sel_h2c_lvl = bus.reg_address == A_H2C_LEVEL;
    assign sel_c2h_lvl = bus.reg_address == A_C2H_LEVEL;
    assign sel_ctrl    = bus.reg_address == A_CTRL;

    assign h2c_empty = h2c_level == '0;
    assign h2c_full  = h2c_level == LW'(pDEPTH);
    assign c2h_empty = c2h_level == '0;
    assign c2h_full  = c2h_level == LW'(pDEPTH);

    // Fullness is judged on the current level, so a same-cycle core pop cannot make room.
    assign h2c_wr      = wr & sel_h2c & lane_ok;
    assign h2c_wr_last = wr & sel_h2c & lane_last;
    assign h2c_push    = h2c_wr_last & ~h2c_full;
    assign h2c_pop     = ~h2c_empty & bus.I_h2c_ready;

    assign c2h_push = bus.I_c2h_valid & ~c2h_full;
    assign c2h_rd   = rd_edge & sel_c2h & lane_ok;
    assign c2h_pop  = c2h_rd & lane_last & ~c2h_empty;

    assign ctrl_wr    = wr & sel_ctrl & lane_zero;
    assign flush_h2c  = ctrl_wr & bus.write_data[0];
    assign flush_c2h  = ctrl_wr & bus.write_data[1];
    assign clr_sticky = ctrl_wr & bus.write_data[2];

    assign status   = {2'b00, c2h_udf, h2c_ovf, c2h_full, c2h_empty, h2c_full, h2c_empty};
    assign c2h_head = c2h_mem[c2h_rp];

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no latch is inferred.
        asm_d     = asm_q;
        push_word = asm_q;
        push_word[(NB-1)*8 +: 8] = bus.write_data;
        for (int i = 0; i < NB; i++) begin
            if (h2c_wr && bus.reg_bytecnt == pBYTECNT_SIZE'(i)) asm_d[i*8 +: 8] = bus.write_data;
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        if (sel_c2h && lane_ok && !c2h_empty) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.reg_bytecnt == pBYTECNT_SIZE'(i)) rd_byte = c2h_head[i*8 +: 8];
            end
        end else if (sel_status) begin
            rd_byte = status;
        end else if (sel_h2c_lvl && lane_zero) begin
            rd_byte = 8'(h2c_level);
        end else if (sel_c2h_lvl && lane_zero) begin
            rd_byte = 8'(c2h_level);
        end
        read_data_d = rd_edge ? rd_byte : read_data_q;
    end

    always_comb begin
        h2c_wp_d    = h2c_push ? h2c_wp + PW'(1) : h2c_wp;
        h2c_rp_d    = h2c_pop  ? h2c_rp + PW'(1) : h2c_rp;
        h2c_level_d = h2c_level;
        if (h2c_push && !h2c_pop)      h2c_level_d = h2c_level + LW'(1);
        else if (h2c_pop && !h2c_push) h2c_level_d = h2c_level - LW'(1);

        c2h_wp_d    = c2h_push ? c2h_wp + PW'(1) : c2h_wp;
        c2h_rp_d    = c2h_pop  ? c2h_rp + PW'(1) : c2h_rp;
        c2h_level_d = c2h_level;
        if (c2h_push && !c2h_pop)      c2h_level_d = c2h_level + LW'(1);
        else if (c2h_pop && !c2h_push) c2h_level_d = c2h_level - LW'(1);

        // Control actions override any traffic on the same FIFO in the same cycle.
        if (flush_h2c) begin
            h2c_wp_d = '0; h2c_rp_d = '0; h2c_level_d = '0;
        end
        if (flush_c2h) begin
            c2h_wp_d = '0; c2h_rp_d = '0; c2h_level_d = '0;
        end

        h2c_ovf_d = clr_sticky ? 1'b0 : (h2c_ovf | (h2c_wr_last & h2c_full));
        c2h_udf_d = clr_sticky ? 1'b0 : (c2h_udf | (c2h_rd & c2h_empty));
        irq_d     = (c2h_level_d != '0) | h2c_ovf_d | c2h_udf_d;
    end

    always_ff @(posedge usb_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            h2c_wp      <= '0;
            h2c_rp      <= '0;
            h2c_level   <= '0;
            c2h_wp      <= '0;
            c2h_rp      <= '0;
            c2h_level   <= '0;
            asm_q       <= '0;
            h2c_ovf     <= 1'b0;
            c2h_udf     <= 1'b0;
            rd_q        <= 1'b0;
            irq_q       <= 1'b0;
            read_data_q <= 8'h00;
        end else begin
            h2c_wp      <= h2c_wp_d;
            h2c_rp      <= h2c_rp_d;
            h2c_level   <= h2c_level_d;
            c2h_wp      <= c2h_wp_d;
            c2h_rp      <= c2h_rp_d;
            c2h_level   <= c2h_level_d;
            asm_q       <= asm_d;
            h2c_ovf     <= h2c_ovf_d;
            c2h_udf     <= c2h_udf_d;
            rd_q        <= bus.reg_read;
            irq_q       <= irq_d;
            read_data_q <= read_data_d;
        end
    end

    // NOTE: FIFO storage has no reset; levels and pointers define validity and the head output is masked when empty.
    always_ff @(posedge usb_clk) begin
        if (h2c_push) h2c_mem[h2c_wp] <= push_word;
        if (c2h_push) c2h_mem[c2h_wp] <= bus.I_c2h_data;
    end

    assign bus.read_data   = read_data_q;
    assign bus.O_h2c_data  = h2c_empty ? '0 : h2c_mem[h2c_rp];
    assign bus.O_h2c_valid = ~h2c_empty;
    assign bus.O_c2h_ready = ~c2h_full;
    assign bus.O_irq       = irq_q;
endmodule

// File: tb/tb_cw305_reg_mailbox_fifo.sv
// Directed bench for the host<->core mailbox: register byte access, both FIFOs,
// sticky flags, flushes and synchronous reset, with hand-computed expectations.
module tb_cw305_reg_mailbox_fifo;
    localparam int AW = 21 - 7;
    localparam int BASE = 8;
    localparam int OFF_H2C = 0, OFF_C2H = 1, OFF_STATUS = 2;
    localparam int OFF_H2C_LVL = 3, OFF_C2H_LVL = 4, OFF_CTRL = 5, OFF_UNMAPPED = 6;

    logic usb_clk = 1'b0;
    logic reset_i = 1'b1;
    int   n_vec   = 0;
    int   n_err   = 0;
    logic [7:0] rb;

    cw305_reg_mailbox_fifo_if #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7), .pDATA_WIDTH(32)) bus ();

    cw305_reg_mailbox_fifo #(
        .pADDR_WIDTH(21), .pBYTECNT_SIZE(7), .pDATA_WIDTH(32), .pDEPTH(8), .pREG_BASE(BASE)
    ) dut (
        .usb_clk(usb_clk),
        .reset_i(reset_i),
        .bus    (bus.slave)
    );

    always #5 usb_clk = ~usb_clk;

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input int off, input int lane);
        bus.reg_address   = AW'(BASE + off);
        bus.reg_bytecnt   = 7'(lane);
        bus.reg_addrvalid = 1'b1;
    endtask

    task automatic host_write(input int off, input int lane, input logic [7:0] d);
        set_bus(off, lane);
        bus.write_data = d;
        bus.reg_write  = 1'b1;
        tick();
        bus.reg_write     = 1'b0;
        bus.reg_addrvalid = 1'b0;
    endtask

    // Strobe, capture the registered byte, then idle a cycle so the next strobe is a new edge.
    task automatic host_read(input int off, input int lane, output logic [7:0] d);
        set_bus(off, lane);
        bus.reg_read = 1'b1;
        tick();
        d = bus.read_data;
        bus.reg_read      = 1'b0;
        bus.reg_addrvalid = 1'b0;
        tick();
    endtask

    task automatic h2c_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) host_write(OFF_H2C, i, w[i*8 +: 8]);
    endtask

    task automatic h2c_push_with_pop(input logic [31:0] w);
        for (int i = 0; i < 3; i++) host_write(OFF_H2C, i, w[i*8 +: 8]);
        bus.I_h2c_ready = 1'b1;
        host_write(OFF_H2C, 3, w[31:24]);
        bus.I_h2c_ready = 1'b0;
    endtask

    task automatic core_push(input logic [31:0] w);
        bus.I_c2h_data  = w;
        bus.I_c2h_valid = 1'b1;
        tick();
        bus.I_c2h_valid = 1'b0;
    endtask

    function automatic logic [31:0] wk(input int k);
        return {8'(8'hA0 + k), 8'(8'hB0 + k), 8'(8'hC0 + k), 8'(8'hD0 + k)};
    endfunction

    initial begin
        bus.reg_address   = '0;
        bus.reg_bytecnt   = '0;
        bus.write_data    = '0;
        bus.reg_read      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_addrvalid = 1'b0;
        bus.I_h2c_ready   = 1'b0;
        bus.I_c2h_data    = '0;
        bus.I_c2h_valid   = 1'b0;
        repeat (3) tick();

        chk("rst_read_data", 32'(bus.read_data), 32'h0);
        chk("rst_h2c_valid", 32'(bus.O_h2c_valid), 32'h0);
        chk("rst_c2h_ready", 32'(bus.O_c2h_ready), 32'h1);
        chk("rst_irq", 32'(bus.O_irq), 32'h0);
        chk("rst_h2c_data", bus.O_h2c_data, 32'h0);
        reset_i = 1'b0;
        tick();
        host_read(OFF_STATUS, 0, rb);
        chk("rst_status", 32'(rb), 32'h05);

        // Host assembles one word
        h2c_word(32'h44332211);
        chk("t1_valid", 32'(bus.O_h2c_valid), 32'h1);
        chk("t1_data", bus.O_h2c_data, 32'h44332211);
        host_read(OFF_H2C_LVL, 0, rb);
        chk("t1_level", 32'(rb), 32'h01);

        // Core fills C2H, host fills H2C and overflows it
        bus.I_c2h_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.I_c2h_data = 32'hC0DE0000 + 32'(i);
            tick();
        end
        bus.I_c2h_valid = 1'b0;
        chk("t2_c2h_ready", 32'(bus.O_c2h_ready), 32'h0);
        host_read(OFF_STATUS, 0, rb);
        chk("t2_status_c2h_full", 32'(rb), 32'h08);
        for (int k = 2; k <= 8; k++) h2c_word(wk(k));
        host_read(OFF_STATUS, 0, rb);
        chk("t2_status_both_full", 32'(rb), 32'h0A);
        h2c_word(wk(9));
        host_read(OFF_STATUS, 0, rb);
        chk("t2_status_ovf", 32'(rb), 32'h1A);
        host_read(OFF_H2C_LVL, 0, rb);
        chk("t2_level_full", 32'(rb), 32'h08);
        chk("t2_head_kept", bus.O_h2c_data, 32'h44332211);

        // Push while full with a same-cycle core pop: push still dropped
        host_write(OFF_CTRL, 0, 8'h04);
        host_read(OFF_STATUS, 0, rb);
        chk("t5_status_cleared", 32'(rb), 32'h0A);
        h2c_push_with_pop(wk(10));
        host_read(OFF_H2C_LVL, 0, rb);
        chk("t5_level_7", 32'(rb), 32'h07);
        host_read(OFF_STATUS, 0, rb);
        chk("t5_status_ovf", 32'(rb), 32'h18);
        chk("t5_head_w2", bus.O_h2c_data, wk(2));
        bus.I_h2c_ready = 1'b1;
        repeat (4) tick();
        bus.I_h2c_ready = 1'b0;
        chk("t5_head_w6", bus.O_h2c_data, wk(6));
        h2c_push_with_pop(wk(11));
        host_read(OFF_H2C_LVL, 0, rb);
        chk("t5_level_3", 32'(rb), 32'h03);
        chk("t5_head_w7", bus.O_h2c_data, wk(7));

        // Fill H2C again, then flush both FIFOs
        for (int k = 12; k <= 16; k++) h2c_word(wk(k));
        host_read(OFF_H2C_LVL, 0, rb);
        chk("t6_level_refill", 32'(rb), 32'h08);
        host_write(OFF_CTRL, 0, 8'h03);
        chk("t6_flush_valid", 32'(bus.O_h2c_valid), 32'h0);
        chk("t6_flush_data", bus.O_h2c_data, 32'h0);
        chk("t6_flush_ready", 32'(bus.O_c2h_ready), 32'h1);
        host_read(OFF_STATUS, 0, rb);
        chk("t6_flush_status", 32'(rb), 32'h15);
        chk("t6_irq_ovf", 32'(bus.O_irq), 32'h1);
        host_write(OFF_CTRL, 0, 8'h04);
        host_read(OFF_STATUS, 0, rb);
        chk("t6_status_clear", 32'(rb), 32'h05);
        chk("t6_irq_clear", 32'(bus.O_irq), 32'h0);

        // Host drains one core word byte by byte
        core_push(32'hDEADBEEF);
        chk("t3_irq_on", 32'(bus.O_irq), 32'h1);
        host_read(OFF_STATUS, 0, rb);
        chk("t3_status", 32'(rb), 32'h01);
        host_read(OFF_C2H, 0, rb);
        chk("t3_lane0", 32'(rb), 32'hEF);
        host_read(OFF_C2H, 1, rb);
        chk("t3_lane1", 32'(rb), 32'hBE);
        host_read(OFF_C2H, 2, rb);
        chk("t3_lane2", 32'(rb), 32'hAD);
        host_read(OFF_C2H_LVL, 0, rb);
        chk("t3_level_before_last", 32'(rb), 32'h01);
        host_read(OFF_C2H, 3, rb);
        chk("t3_lane3", 32'(rb), 32'hDE);
        chk("t3_irq_off", 32'(bus.O_irq), 32'h0);
        host_read(OFF_C2H_LVL, 0, rb);
        chk("t3_level_after_last", 32'(rb), 32'h00);

        // Underflow
        host_read(OFF_C2H, 3, rb);
        chk("t4_udf_data", 32'(rb), 32'h00);
        chk("t4_udf_irq", 32'(bus.O_irq), 32'h1);
        host_read(OFF_STATUS, 0, rb);
        chk("t4_status_udf", 32'(rb), 32'h25);
        host_write(OFF_CTRL, 0, 8'h04);
        host_read(OFF_STATUS, 0, rb);
        chk("t4_status_clear", 32'(rb), 32'h05);
        host_write(OFF_UNMAPPED, 0, 8'hFF);
        host_read(OFF_UNMAPPED, 0, rb);
        chk("unmapped_read", 32'(rb), 32'h00);

        // Reset in the middle of assembling a word
        h2c_word(32'h12345678);
        core_push(32'h0BADF00D);
        host_read(OFF_C2H_LVL, 0, rb);
        chk("t6_pre_reset_level", 32'(rb), 32'h01);
        host_write(OFF_H2C, 0, 8'h55);
        host_write(OFF_H2C, 1, 8'h66);
        reset_i = 1'b1;
        tick();
        chk("t6_rst_read_data", 32'(bus.read_data), 32'h0);
        chk("t6_rst_valid", 32'(bus.O_h2c_valid), 32'h0);
        chk("t6_rst_ready", 32'(bus.O_c2h_ready), 32'h1);
        chk("t6_rst_irq", 32'(bus.O_irq), 32'h0);
        chk("t6_rst_data", bus.O_h2c_data, 32'h0);
        reset_i = 1'b0;
        tick();
        host_write(OFF_H2C, 2, 8'h77);
        host_write(OFF_H2C, 3, 8'h88);
        chk("t6_asm_discarded", bus.O_h2c_data, 32'h88770000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
